ram_dp_param: RTL and testbench
===============================

# ram_dp_param

Parametrised simple-dual-port synchronous RAM: one write port and one read port sharing a single clock, with configurable data width and depth. It provides a registered read with a `rd_valid` qualifier, write-first forwarding on same-address read/write, and a hardware clear sequencer that zeroes every location after reset. It replaces the fixed 4096-deep memory as the storage element behind the memory-chip wrapper and connects to the same `ram_if` signal set, extended with `rd_valid` and `init_busy`.

## Interface
- `DATA_WIDTH`, 64, bits per word.
- `ADDR_WIDTH`, 12, address bits. Depth is fixed at `2**ADDR_WIDTH` words.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  write data.
- `wr_address`  in  ADDR_WIDTH  write address.
- `write`  in  1  write strobe; sampled each rising edge.
- `rd_address`  in  ADDR_WIDTH  read address.
- `read`  in  1  read strobe; sampled each rising edge.
- `data_out`  out  DATA_WIDTH  read data; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse marking new `data_out`.
- `init_busy`  out  1  high while the clear sequencer runs; strobes are ignored.

## Operation
- FSM states:
  - INIT:
    - Entered on any edge with `reset`=1.
    - An address counter starts at 0. Each edge with `reset`=0 writes 0 to `mem[counter]` and increments the counter.
    - When `counter == 2**ADDR_WIDTH-1` is written, the FSM goes to READY. The counter wraps to 0 and is unused in READY.
  - READY:
    - The FSM stays in READY until `reset` is asserted.
- `init_busy` = 1 in INIT and 0 in READY.
- In INIT, `read` and `write` are ignored. No memory update comes from the ports, and `rd_valid` stays 0.
- Write in READY: `write`=1 stores `data_in` to `mem[wr_address]` on the edge.
- Read in READY: `read`=1 captures `mem[rd_address]` into the output stage.
- Same-address collision:
  - Condition: `read`=1, `write`=1 and `rd_address == wr_address` on the same edge.
  - Behaviour is write-first: `data_out` returns the new `data_in`, not the old contents.
- Different-address read and write on the same edge: both complete independently.
- When no read occurs, `data_out` keeps its last value and `rd_valid`=0.
- Reset mid-operation:
  - Reset aborts any in-flight read, so no `rd_valid` is produced for it.
  - Reset restarts INIT from address 0, even if a previous INIT was incomplete.
  - Memory contents are only guaranteed zero once INIT completes.

## Timing
- Reset values (edge with `reset`=1):
  - `data_out` = 0.
  - `rd_valid` = 0.
  - `init_busy` = 1.
  - Internal pipeline valid flags are cleared.
- INIT duration:
  - INIT lasts exactly `2**ADDR_WIDTH` edges after reset is released.
  - `init_busy` falls after the edge that writes the last address.
  - The next edge is the first one that accepts strobes.
- Read latency is 1 cycle by default:
  - A read sampled at edge N drives `data_out`/`rd_valid` valid after edge N.
  - `rd_valid` is high for exactly one cycle per accepted read.
  - Back-to-back reads give one result per cycle.
- Write latency: a write at edge N is visible to a read sampled at edge N (forwarded) and at any later edge.

## Configuration
- Macro: `RAM_OUT_REG_EN`.
- Defined:
  - An extra output register stage follows the array read.
  - Read latency becomes 2 cycles: the read sampled at edge N presents `data_out` and `rd_valid` after edge N+1.
  - Full throughput is kept.
  - Collision forwarding is captured at edge N and travels through both stages.
  - Reset clears both stages.
- Not defined: single-stage behaviour as specified above (latency 1).

## Test plan
- Init: release `reset` and count cycles with `init_busy`=1, expecting 4096. Then read addresses 0, 1 and 4095, expecting `data_out`=0 each with `rd_valid` pulses.
- Write/read: write 64'hDEAD_BEEF_0123_4567 to 12'h0A5, then read 12'h0A5 on the next edge. Expect that value with latency 1 (2 with `RAM_OUT_REG_EN`).
- Collision: 12'h100 holds 64'h1111. Read 12'h100 and write 64'h2222 to it on the same edge; expect `data_out`=64'h2222. A later read also returns 64'h2222.
- Strobe blocking: assert `write` with 64'hFF to 12'h003 and `read` during INIT. Expect `rd_valid` to stay 0 and a post-INIT read of 12'h003 to return 0.
- Streaming and boundaries: write addresses 0..4095 with data = address. Read 4095, 0, 1 back-to-back and expect 4095, 0, 1 on consecutive cycles. Cycles without a read hold `data_out` with `rd_valid`=0.
- Reset mid-operation:
  - Assert `reset` for 1 cycle while a read is in flight and again 100 cycles into INIT.
  - Expect no `rd_valid` for the in-flight read, `data_out`=0, and a full 4096-cycle INIT restart each time.

Source files
------------

// File: rtl/ram_dp_param.sv
// ram_dp_param: simple dual-port synchronous RAM with write-first forwarding and a post-reset
// clear sequencer. Define RAM_OUT_REG_EN to add a second output register stage (read latency 2).
module ram_dp_param #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  init_busy
);

  // state    | meaning
  // ST_INIT  | clear sequencer zeroing mem[cnt_q]; port strobes ignored
  // ST_READY | normal read/write operation
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_LAST) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready     = (state_q == ST_READY);
  assign init_busy = ~ready;

  // The single write port is shared between the clear sequencer and the user write path.
  assign mem_we = ~reset & (ready ? write : 1'b1);
  assign mem_wa = ready ? wr_address : cnt_q;
  assign mem_wd = ready ? data_in : '0;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign rd_accept = ready & read;
  assign rd_word   = (write && (rd_address == wr_address)) ? data_in : mem_q[rd_address];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= rd_word;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) out_data_q <= rd_data_q;
    end
  end

  assign data_out = out_data_q;
  assign rd_valid = out_valid_q;
`else
  assign data_out = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: randomized scoreboard bench for ram_dp_param against an array reference model.
module tb_ram_dp_param;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int DEPTH = 4096;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic [AW-1:0] wr_address;
  logic          write;
  logic [AW-1:0] rd_address;
  logic          read;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          init_busy;

  ram_dp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_address(wr_address), .write(write),
    .rd_address(rd_address), .read(read), .data_out(data_out), .rd_valid(rd_valid),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc = 0;
  int            rst_cyc = -1;
  int            init_left = DEPTH;
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock edge: inputs are applied now and sampled at the next rising edge.
  task automatic drive(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit r, input logic [AW-1:0] ra, input bit rst);
    exp_t e;
    reset = rst; write = w; wr_address = wa; data_in = wd; read = r; rd_address = ra;
    if (rst) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due >= cyc + 1) sb.delete(i);
      rst_cyc = cyc + 1;
    end else if (init_left == 0) begin
      if (w) ref_mem[wa] = wd;
      if (r) begin
        e.data = ref_mem[ra];
        e.due  = cyc + LAT;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #2;
    if (rst) begin
      init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (init_left > 0) begin
      init_left--;
    end
    chk("init_busy", {63'd0, init_busy}, {63'd0, init_left != 0});
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, a, d, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b0, '0, '0, 1'b1, a, 1'b0);
  endtask

  task automatic count_init(input string nm, input int start);
    int n;
    n = start;
    while (init_busy === 1'b1 && n < 5000) begin
      idle();
      n++;
    end
    chk(nm, n, 4096);
  endtask

  // Monitor: pops the scoreboard on every rd_valid and checks data_out holds otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (cyc == rst_cyc) last_exp = '0;
        if (rd_valid === 1'b1) begin
          if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_rd_valid: got 1 expected 0 (edge %0d)", cyc);
          end else begin
            chk("rd_latency", sb[0].due, cyc);
            chk("rd_data", data_out, sb[0].data);
            last_exp = sb[0].data;
            void'(sb.pop_front());
          end
        end else begin
          chk("rd_valid_low", {63'd0, rd_valid}, '0);
          if (sb.size() > 0 && sb[0].due <= cyc) begin
            errors++;
            checks++;
            $display("FAIL missing_rd_valid: got none expected data %h (edge %0d)", sb[0].data, cyc);
            void'(sb.pop_front());
          end
          chk("data_hold", data_out, last_exp);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    reset = 1'b1; write = 1'b0; read = 1'b0; data_in = '0; wr_address = '0; rd_address = '0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    chk("rst_data_out", data_out, '0);
    chk("rst_rd_valid", {63'd0, rd_valid}, '0);

    // Strobes during INIT must be ignored; the init count includes these cycles.
    for (int i = 0; i < 4; i++) drive(1'b1, 12'h003, 64'hFF, 1'b1, 12'h003, 1'b0);
    count_init("init_cycles", 4);

    rd(12'h000); rd(12'h001); rd(12'hFFF); rd(12'h003);
    idle();

    wr(12'h0A5, 64'hDEAD_BEEF_0123_4567);
    rd(12'h0A5);
    idle(); idle();

    wr(12'h100, 64'h1111);
    idle();
    drive(1'b1, 12'h100, 64'h2222, 1'b1, 12'h100, 1'b0);
    idle();
    rd(12'h100);
    idle(); idle();

    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa, ra;
      wa = AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      drive($urandom_range(0, 1) == 1, wa, {$urandom, $urandom}, $urandom_range(0, 2) != 0, ra, 1'b0);
    end
    idle(); idle();

    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      wr(a, {52'd0, a});
    end
    rd(12'hFFF); rd(12'h000); rd(12'h001);
    idle(); idle(); idle();

    // Reset while a read is in flight, then a reset 100 cycles into the following INIT.
    rd(12'hFFF);
    drive(1'b0, '0, '0, 1'b1, 12'h005, 1'b1);
    chk("midrst_data_out", data_out, '0);
    count_init("init_restart1", 0);
    rd(12'h0A5);
    idle(); idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 100; i++) idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    count_init("init_restart2", 0);
    rd(12'hFFF); rd(12'h0A5);
    for (int i = 0; i < LAT + 3; i++) idle();

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
